// File: rtl/i2c_buf_pkg.sv
// Shared constants and helpers for the I2C receive byte buffer.
//   WIDTH_DEFAULT / DEPTH_DEFAULT : default byte width and FIFO depth
//   clog2()                       : pointer width from depth
//   ST_*                          : bit positions inside the 6-bit debug state vector
package i2c_buf_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;
   localparam int unsigned DEPTH_DEFAULT = 8;

   // Debug state vector layout: {overflow, full, empty, rd_ptr[2:0]}
   localparam int unsigned ST_W     = 6;
   localparam int unsigned ST_OVF   = 5;
   localparam int unsigned ST_FULL  = 4;
   localparam int unsigned ST_EMPTY = 3;
   localparam int unsigned ST_PTR_W = 3;

   // Ceiling log2, usable in constant expressions
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = 32'(i + 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/i2c_rx_buffer_rise_detect.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level is seen high.
//   clk, reset : clock and asynchronous active-high reset
//   in         : level input
//   pulse      : in & ~(in delayed one cycle)
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic in_d;

   // Previous-cycle copy of the level; clears on reset so a level held
   // through reset release is seen as a fresh edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) in_d <= 1'b0;
      else       in_d <= in;
   end

   assign pulse = in & ~in_d;

endmodule

// File: rtl/i2c_rx_buffer.sv
// Circular byte FIFO behind the I2C master's receive handshake; the show key
// steps through stored bytes one at a time.
//   clk, reset   : clock, asynchronous active-high reset
//   datareceive  : byte from the master, sampled on the rising edge of received
//   received     : receive-complete level; one push per assertion
//   swShow       : debounced show key level; one pop per press
//   clear        : synchronous flush of pointers, count and overflow
//   out          : last popped byte (held across clear and empty pops)
//   count        : stored bytes 0..DEPTH
//   empty, full  : decoded from count
//   overflow     : sticky, a byte was dropped while full
//   state        : debug {overflow, full, empty, rd_ptr[2:0]}
// DEPTH must be a power of two (2..256) so the pointers wrap naturally.
module i2c_rx_buffer
   import i2c_buf_pkg::*;
#(
   parameter  int unsigned WIDTH = WIDTH_DEFAULT,
   parameter  int unsigned DEPTH = DEPTH_DEFAULT,
   localparam int unsigned AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] datareceive,
   input  logic             received,
   input  logic             swShow,
   input  logic             clear,
   output logic [WIDTH-1:0] out,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic [ST_W-1:0]  state
);

   logic             push;
   logic             pop;
   logic             do_push;
   logic             do_pop;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   rise_detect u_rx_edge (
      .clk   (clk),
      .reset (reset),
      .in    (received),
      .pulse (push)
   );

   rise_detect u_show_edge (
      .clk   (clk),
      .reset (reset),
      .in    (swShow),
      .pulse (pop)
   );

   assign empty = (count == (AW+1)'(0));
   assign full  = (count == (AW+1)'(DEPTH));

   // A pop is ignored when empty (no bypass); a push when full only lands
   // if a pop frees the slot on the same edge.
   always_comb begin
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
   end

   // Pointers, count, overflow and the presented byte
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         out      <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            out    <= mem[rd_ptr];
         end
         if (push & ~do_push) overflow <= 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; stale entries are never read past count.
   always_ff @(posedge clk) begin
      if (do_push & ~clear) mem[wr_ptr] <= datareceive;
   end

   assign state = {overflow, full, empty, ST_PTR_W'(rd_ptr)};

endmodule
